// File: rtl/reg_scoreboard.sv
// Register-write scoreboard: tracks in-flight long-latency writes per tag and
// exposes pending destinations. Optional sticky protocol checker: SCOREBOARD_ERR_CHECK_EN.
module reg_scoreboard #(
    parameter int unsigned NUM_TAGS = 8,
    parameter int unsigned TAG_W    = $clog2(NUM_TAGS),
    parameter int unsigned CNT_W    = $clog2(NUM_TAGS) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [4:0]       issue_rd,
    input  logic             issue_reg_write,
    input  logic             issue_spec,
    output logic [TAG_W-1:0] issue_tag,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic             flush,
    input  logic             spec_resolve,
    input  logic [4:0]       query_rs1,
    input  logic [4:0]       query_rs2,
    output logic             rs1_busy,
    output logic             rs2_busy,
    output logic [31:0]      reg_write_bitmap,
    output logic [CNT_W-1:0] inflight_count,
    output logic             full,
    output logic             scoreboard_enable,
    output logic             sb_error
);

    typedef enum logic {SB_OFF, SB_ON} sb_state_t;

    sb_state_t state_q, state_d;

    logic [NUM_TAGS-1:0] valid_q;
    logic [NUM_TAGS-1:0] spec_q;
    logic [4:0]          rd_q [NUM_TAGS];
    logic [TAG_W-1:0]    free_tag;
    logic                handshake;
    logic                alloc;

    always_ff @(posedge clk) begin
        if (rst) state_q <= SB_OFF;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SB_OFF:  state_d = SB_ON;
            SB_ON:   state_d = SB_ON;
            default: state_d = SB_OFF;
        endcase
    end

    always_comb begin
        scoreboard_enable = (state_q == SB_ON);
    end

    // Lowest free index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        free_tag = '0;
        for (int unsigned i = NUM_TAGS; i > 0; i--) begin
            if (!valid_q[i-1]) free_tag = TAG_W'(i - 1);
        end
    end

    always_comb begin
        inflight_count   = '0;
        reg_write_bitmap = '0;
        for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            inflight_count = inflight_count + CNT_W'(valid_q[i]);
            if (valid_q[i]) reg_write_bitmap[rd_q[i]] = 1'b1;
        end
    end

    always_comb begin
        full        = (inflight_count == CNT_W'(NUM_TAGS));
        issue_ready = scoreboard_enable & ~full & ~flush;
        handshake   = issue_valid & issue_ready;
        alloc       = handshake & issue_reg_write & (issue_rd != 5'd0);
        issue_tag   = free_tag;
        rs1_busy    = (query_rs1 != 5'd0) & reg_write_bitmap[query_rs1];
        rs2_busy    = (query_rs2 != 5'd0) & reg_write_bitmap[query_rs2];
    end

    // Order matters: flush beats spec_resolve; allocation targets a free slot so
    // it never collides with the writeback/flush clears of a live slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            spec_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_TAGS; i++) begin
                if (wb_valid && wb_tag == TAG_W'(i) && valid_q[i]) begin
                    valid_q[i] <= 1'b0;
                    spec_q[i]  <= 1'b0;
                end
                if (flush) begin
                    if (spec_q[i]) begin
                        valid_q[i] <= 1'b0;
                        spec_q[i]  <= 1'b0;
                    end
                end else if (spec_resolve) begin
                    spec_q[i] <= 1'b0;
                end
                if (alloc && free_tag == TAG_W'(i)) begin
                    valid_q[i] <= 1'b1;
                    spec_q[i]  <= issue_spec;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) rd_q[free_tag] <= issue_rd;
    end

`ifdef SCOREBOARD_ERR_CHECK_EN
    logic [NUM_TAGS-1:0] flushed_q;
    logic                err_q;

    // A flushed slot may still see its late writeback; that is legal until reallocated.
    always_ff @(posedge clk) begin
        if (rst) begin
            flushed_q <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_TAGS; i++) begin
                if (alloc && free_tag == TAG_W'(i))
                    flushed_q[i] <= 1'b0;
                else if (flush && valid_q[i] && spec_q[i])
                    flushed_q[i] <= 1'b1;
            end
            if ((wb_valid && !valid_q[wb_tag] && !flushed_q[wb_tag]) ||
                (issue_valid && !scoreboard_enable))
                err_q <= 1'b1;
        end
    end

    always_comb begin
        sb_error = err_q;
    end
`else
    always_comb begin
        sb_error = 1'b0;
    end
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: per-register reference counts model plus directed
// scenarios; expected sb_error depends on SCOREBOARD_ERR_CHECK_EN.
module tb_reg_scoreboard;

`ifdef SCOREBOARD_ERR_CHECK_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_ready, issue_reg_write, issue_spec;
    logic [4:0]  issue_rd;
    logic [2:0]  issue_tag;
    logic        wb_valid;
    logic [2:0]  wb_tag;
    logic        flush, spec_resolve;
    logic [4:0]  query_rs1, query_rs2;
    logic        rs1_busy, rs2_busy;
    logic [31:0] reg_write_bitmap;
    logic [3:0]  inflight_count;
    logic        full, scoreboard_enable, sb_error;

    int total = 0;
    int bad   = 0;

    reg_scoreboard #(.NUM_TAGS(8)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
        .issue_reg_write(issue_reg_write), .issue_spec(issue_spec), .issue_tag(issue_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .flush(flush), .spec_resolve(spec_resolve),
        .query_rs1(query_rs1), .query_rs2(query_rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .reg_write_bitmap(reg_write_bitmap), .inflight_count(inflight_count), .full(full),
        .scoreboard_enable(scoreboard_enable), .sb_error(sb_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a set of occupied tags and a per-register count of pending writers.
    bit m_init = 1'b0;
    bit m_en, m_err;
    bit m_busy [N];
    bit m_spec [N];
    bit m_fl   [N];
    int m_rd   [N];
    int reg_cnt[32];

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_busy[i]) c++;
        return c;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
        return 0;
    endfunction

    function automatic logic [31:0] m_bitmap();
        logic [31:0] b = '0;
        for (int r = 1; r < 32; r++) b[r] = (reg_cnt[r] > 0);
        return b;
    endfunction

    function automatic void m_release(input int t);
        m_busy[t] = 1'b0;
        m_spec[t] = 1'b0;
        reg_cnt[m_rd[t]]--;
    endfunction

    always @(posedge clk) begin
        bit ready, alloc;
        bit kill [N];
        int t;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_busy[i] = 0; m_spec[i] = 0; m_fl[i] = 0; m_rd[i] = 0;
            end
            for (int r = 0; r < 32; r++) reg_cnt[r] = 0;
            m_en = 0; m_err = 0; m_init = 1;
        end else if (m_init) begin
            ready = m_en && (m_count() != N) && !flush;
            alloc = issue_valid && ready && issue_reg_write && (issue_rd != 0);
            t = m_free();
            if (ERR && ((wb_valid && !m_busy[wb_tag] && !m_fl[wb_tag]) || (issue_valid && !m_en)))
                m_err = 1;
            for (int i = 0; i < N; i++) begin
                kill[i] = flush && m_busy[i] && m_spec[i];
                if (kill[i]) m_fl[i] = 1;
            end
            if (wb_valid && m_busy[wb_tag]) m_release(int'(wb_tag));
            for (int i = 0; i < N; i++) if (kill[i] && m_busy[i]) m_release(i);
            if (!flush && spec_resolve) for (int i = 0; i < N; i++) m_spec[i] = 0;
            if (alloc) begin
                m_busy[t] = 1; m_rd[t] = int'(issue_rd); m_spec[t] = issue_spec; m_fl[t] = 0;
                reg_cnt[issue_rd]++;
            end
            m_en = 1;
        end
    end

    always @(negedge clk) begin
        logic [31:0] eb;
        if (m_init) begin
            eb = m_bitmap();
            check("bitmap", reg_write_bitmap, eb);
            check("count", 32'(inflight_count), 32'(m_count()));
            check("full", 32'(full), 32'(m_count() == N));
            check("enable", 32'(scoreboard_enable), 32'(m_en));
            check("ready", 32'(issue_ready), 32'(m_en && m_count() != N && !flush));
            check("rs1_busy", 32'(rs1_busy), 32'(eb[query_rs1]));
            check("rs2_busy", 32'(rs2_busy), 32'(eb[query_rs2]));
            check("sb_error", 32'(sb_error), 32'(m_err));
            if (m_count() != N) check("issue_tag", 32'(issue_tag), 32'(m_free()));
        end
    end

    task automatic idle();
        issue_valid = 0; issue_reg_write = 0; issue_rd = 0; issue_spec = 0;
        wb_valid = 0; wb_tag = 0; flush = 0; spec_resolve = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        idle();
        #1;
    endtask

    task automatic issue(input int rd, input bit sp, input int exp_tag);
        issue_valid = 1; issue_reg_write = 1; issue_rd = 5'(rd); issue_spec = sp;
        #1;
        if (exp_tag >= 0) check("issue_tag_lit", 32'(issue_tag), 32'(exp_tag));
        tick();
    endtask

    task automatic wb(input int t);
        wb_valid = 1; wb_tag = 3'(t);
        tick();
    endtask

    task automatic do_reset();
        rst = 1; tick();
        rst = 0;
    endtask

    initial begin
        rst = 1; idle(); query_rs1 = 0; query_rs2 = 0;
        repeat (2) @(posedge clk);
        #3;
        check("rst_enable", 32'(scoreboard_enable), 0);
        check("rst_bitmap", reg_write_bitmap, 0);
        check("rst_count", 32'(inflight_count), 0);
        check("rst_ready", 32'(issue_ready), 0);
        check("rst_full", 32'(full), 0);
        rst = 0; tick();
        check("enable_up", 32'(scoreboard_enable), 1);

        // single issue/writeback
        query_rs1 = 5; query_rs2 = 7;
        issue(5, 0, 0);
        check("t1_bitmap", reg_write_bitmap, 32'h0000_0020);
        check("t1_count", 32'(inflight_count), 1);
        check("t1_rs1_busy", 32'(rs1_busy), 1);
        wb(0);
        check("t1_bitmap_clr", reg_write_bitmap, 0);

        // shared rd
        issue(7, 0, 0);
        issue(7, 0, 1);
        wb(0);
        check("t2_bit7_held", reg_write_bitmap, 32'h0000_0080);
        check("t2_rs2_busy", 32'(rs2_busy), 1);
        wb(1);
        check("t2_bitmap_clr", reg_write_bitmap, 0);
        check("t2_count", 32'(inflight_count), 0);

        // fill, stall, reuse freed tag
        for (int i = 0; i < N; i++) issue(i + 1, 0, i);
        check("t3_full", 32'(full), 1);
        check("t3_count", 32'(inflight_count), 8);
        issue_valid = 1; issue_reg_write = 1; issue_rd = 20;
        #1;
        check("t3_ready_low", 32'(issue_ready), 0);
        tick();
        check("t3_no_alloc", reg_write_bitmap, 32'h0000_01FE);
        wb(3);
        check("t3_after_wb", reg_write_bitmap, 32'h0000_01EE);
        issue(20, 0, 3);
        check("t3_reuse", reg_write_bitmap, 32'h0010_01EE);
        for (int i = 0; i < N; i++) wb(i);
        check("t3_drained", 32'(inflight_count), 0);

        // flush drops speculative only
        issue(3, 0, 0);
        issue(4, 1, 1);
        issue(9, 1, 2);
        flush = 1;
        #1;
        check("t4_ready_flush", 32'(issue_ready), 0);
        tick();
        check("t4_bitmap", reg_write_bitmap, 32'h0000_0008);
        check("t4_count", 32'(inflight_count), 1);
        wb(0);

        // flush beats resolve; resolve alone protects
        issue(4, 1, 0);
        flush = 1; spec_resolve = 1; tick();
        check("t5_dropped", reg_write_bitmap, 0);
        issue(4, 1, 0);
        spec_resolve = 1; tick();
        flush = 1; tick();
        check("t5_survives", reg_write_bitmap, 32'h0000_0010);
        wb(0);

        // rd=0 / reg_write=0 allocate nothing
        issue(0, 0, -1);
        issue_valid = 1; issue_reg_write = 0; issue_rd = 5; tick();
        check("t6_no_alloc", 32'(inflight_count), 0);

        // writeback alongside allocation
        issue(11, 0, 0);
        issue_valid = 1; issue_reg_write = 1; issue_rd = 12; wb_valid = 1; wb_tag = 0;
        #1;
        check("t7_tag", 32'(issue_tag), 1);
        tick();
        check("t7_bitmap", reg_write_bitmap, 32'h0000_1000);
        wb(1);

        // writeback + flush on same spec entry, then late wb to flushed tag
        issue(10, 1, 0);
        issue(13, 1, 1);
        flush = 1; wb_valid = 1; wb_tag = 0; tick();
        check("t8_bitmap", reg_write_bitmap, 0);
        wb(1);
        check("t8_no_err", 32'(sb_error), 0);

        // issue while disabled, then writeback to never-used tag
        do_reset();
        issue_valid = 1; issue_reg_write = 1; issue_rd = 6; tick();
        check("t9_disabled_err", 32'(sb_error), 32'(ERR));
        check("t9_no_alloc", 32'(inflight_count), 0);
        do_reset(); tick();
        wb(6);
        check("t9_wb_free_err", 32'(sb_error), 32'(ERR));
        repeat (3) tick();
        check("t9_sticky", 32'(sb_error), 32'(ERR));

        // reset mid-operation
        issue(15, 0, 0);
        issue(16, 1, 1);
        do_reset();
        check("t10_rst_bitmap", reg_write_bitmap, 0);
        check("t10_rst_err", 32'(sb_error), 0);
        tick();

        // mixed traffic
        for (int c = 0; c < 400; c++) begin
            issue_valid = 1'($urandom_range(0, 1));
            issue_reg_write = ($urandom_range(0, 7) != 0);
            issue_rd = 5'($urandom_range(0, 9));
            issue_spec = 1'($urandom_range(0, 1));
            wb_valid = ($urandom_range(0, 2) == 0);
            wb_tag = 3'($urandom_range(0, 7));
            flush = ($urandom_range(0, 11) == 0);
            spec_resolve = ($urandom_range(0, 7) == 0);
            query_rs1 = 5'($urandom_range(0, 9));
            query_rs2 = 5'($urandom_range(0, 9));
            tick();
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks in-flight long-latency register writes (loads, mul/div) between issue and writeback.
- Issue allocates a tag per pending write; writeback releases it.
- Produces reg_write_bitmap and scoreboard_enable, which the hazard unit consumes for stall decisions.
- Sits beside the ID/EX boundary. Speculative entries are dropped on branch-mispredict flush.

Parameters:
- NUM_TAGS, 8, number of in-flight write slots (power of two, 2..16).
- TAG_W, $clog2(NUM_TAGS), width of tag ports.
- CNT_W, $clog2(NUM_TAGS)+1, width of inflight_count.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- issue_valid  in  1  EX offers an instruction for tracking.
- issue_ready  out  1  scoreboard can accept the issue this cycle.
- issue_rd  in  5  destination register.
- issue_reg_write  in  1  instruction writes issue_rd.
- issue_spec  in  1  instruction is younger than an unresolved branch.
- issue_tag  out  TAG_W  tag allocated on handshake (lowest free index).
- wb_valid  in  1  writeback completes for wb_tag.
- wb_tag  in  TAG_W  tag being released.
- flush  in  1  branch mispredict; drop speculative entries.
- spec_resolve  in  1  branch resolved correctly; all entries become non-speculative.
- query_rs1, query_rs2  in  5 each  ID-stage source registers.
- rs1_busy, rs2_busy  out  1 each  source register has a pending write.
- reg_write_bitmap  out  32  bit r set iff at least one valid entry has rd==r.
- inflight_count  out  CNT_W  number of valid entries.
- full  out  1  no free tag.
- scoreboard_enable  out  1  scoreboard is operational.
- sb_error  out  1  sticky protocol error (optional feature only).

Behaviour:
- State: per-tag {valid, rd[4:0], spec}, plus scoreboard_enable_q and sb_error_q.
- Reset (rst=1 at edge): all valid=0 and spec=0; scoreboard_enable=0; sb_error=0. Derived outputs follow: bitmap=0, inflight_count=0, full=0, busy=0. issue_ready=0 while rst=1.
- scoreboard_enable goes to 1 at the first edge with rst=0 and stays 1 until the next reset.
- issue_ready = scoreboard_enable & ~full & ~flush.
- Handshake = issue_valid & issue_ready.
  - Allocation occurs only when the handshake fires with issue_reg_write=1 and issue_rd!=0.
  - A handshake with rd==0 or reg_write=0 is accepted but allocates nothing; issue_tag is don't-care.
- issue_tag is combinational: lowest index with valid=0.
- On allocation, entry[issue_tag] is written {1, issue_rd, issue_spec} at the edge.
  - The bitmap bit, busy flags and inflight_count reflect it from the next cycle (1-cycle latency).
- Writeback: wb_valid with entry[wb_tag].valid=1 clears that entry's valid at the edge. The bitmap bit clears next cycle only if no other valid entry has the same rd.
- Writeback to an entry with valid=0 is ignored; state is unchanged.
- flush: at the edge, every entry with spec=1 is cleared (valid=0, spec=0). Non-speculative entries are untouched.
- spec_resolve: at the edge, all spec bits clear.
  - If flush and spec_resolve are both 1, flush wins; spec_resolve is ignored that cycle.
- Simultaneous writeback and flush on the same speculative entry: the entry is cleared; no error.
- Simultaneous writeback of tag T and allocation: the allocated tag can never be T, since T is valid. Both take effect.
- Multiple valid entries may share an rd. The bitmap bit stays set until the last of them releases.
- rs1_busy = reg_write_bitmap[query_rs1]; rs2_busy = reg_write_bitmap[query_rs2]. Both are combinational from registered state. Register x0 always reads 0.
- full = (inflight_count == NUM_TAGS).
- Reset mid-operation: all pending entries are discarded; no writeback is required afterwards.

Optional Feature:
- Macro: SCOREBOARD_ERR_CHECK_EN.
- Defined: sb_error sets (sticky until rst) on any of:
  - wb_valid to a tag with valid=0, unless that tag was cleared by flush in the same cycle or earlier since its last allocation; a per-tag "flushed" bit is kept for this;
  - issue_valid while scoreboard_enable=0.
- Undefined: sb_error is tied to 0 and no per-tag flushed bits exist.

Test Plan:
- Reset, then issue rd=5 non-spec -> issue_tag=0; next cycle bitmap=32'h0000_0020, inflight_count=1, rs1_busy=1 with query_rs1=5. wb_tag=0 -> bitmap=0 the following cycle.
- Issue rd=7 twice (tags 0 and 1); wb tag 0 -> bit 7 still set; wb tag 1 -> bit 7 clears, inflight_count=0.
- Fill 8 tags -> full=1, issue_ready=0, a stalled issue_valid is held without allocation. wb tag 3 -> next issue gets tag 3.
- Issue rd=3 non-spec, rd=4 spec, rd=9 spec; pulse flush -> bitmap=32'h0000_0008, inflight_count=1, issue_ready=0 during the flush cycle.
- Issue rd=4 spec; assert spec_resolve and flush together -> entry dropped. Repeat with spec_resolve alone, then flush -> entry survives.
- Issue rd=0 -> no allocation, bitmap stays 0. With SCOREBOARD_ERR_CHECK_EN, wb to free tag 6 -> sb_error=1 until rst; without the macro sb_error stays 0.
